// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths and shared types for the multi-port register file
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode (read/claim) and writeback (write) bus of the register file
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) ();
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic                     claim_hit;
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_data, rd_busy, claim_hit
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        output rd_data, rd_busy, claim_hit
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, set on claim and cleared on writeback
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [2**ADDR_W-1:0]     busy,
    output logic [2**ADDR_W-1:0]     busy_nxt,
    output logic                     claim_hit
);
    // claim is applied after releases: a same-cycle claim is the newer producer
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j]) busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        if (claim_en) busy_nxt[claim_addr] = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            claim_hit <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            claim_hit <= claim_en & busy[claim_addr];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, optional write-first
// bypass, optional hardwired zero register and a busy scoreboard
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] we;
    logic [DATA_W-1:0] rd_nxt [NUM_RD];
    logic [NUM_RD-1:0] busy_rd;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign ra[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end
    // writes to a hardwired zero register never reach storage nor the bypass path
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
        assign wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
        assign we[j] = bus.wr_en[j] && !(ZERO_REG && wa[j] == '0);
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .claim_en   (bus.claim_en),
        .claim_addr (bus.claim_addr),
        .busy       (busy),
        .busy_nxt   (busy_nxt),
        .claim_hit  (bus.claim_hit)
    );

    // ascending port scan lets the highest-index writer win the bypass
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_nxt[i] = mem[ra[i]];
            for (int j = 0; j < NUM_WR; j++)
                if (BYPASS && we[j] && wa[j] == ra[i]) rd_nxt[i] = wd[j];
            busy_rd[i] = BYPASS ? busy_nxt[ra[i]] : busy[ra[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
            bus.rd_data <= '0;
            bus.rd_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (we[j]) mem[wa[j]] <= wd[j];
            for (int i = 0; i < NUM_RD; i++)
                if (bus.rd_en[i]) begin
                    bus.rd_data[i*DATA_W +: DATA_W] <= rd_nxt[i];
                    bus.rd_busy[i]                  <= busy_rd[i];
                end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two builds (bypass+zero-reg, read-first+plain r0) under shared
// stimulus, checked against a behavioural model through an expectation queue
module tb_regfile_mp;
    import regfile_pkg::*;
    localparam int DW = 32, AW = 5, NR = 2, NW = 2, DEPTH = 32;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] port;
        data_t      data;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic act = 1'b0, act_d = 1'b0;
    logic [NR-1:0] en_d = '0;
    int npass = 0, nchk = 0;
    exp_t q[$];
    data_t mem_m [2][DEPTH];
    logic busy_m [2][DEPTH];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_a ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_b ();
    assign bus_b.rd_en      = bus_a.rd_en;
    assign bus_b.rd_addr    = bus_a.rd_addr;
    assign bus_b.wr_en      = bus_a.wr_en;
    assign bus_b.wr_addr    = bus_a.wr_addr;
    assign bus_b.wr_data    = bus_a.wr_data;
    assign bus_b.claim_en   = bus_a.claim_en;
    assign bus_b.claim_addr = bus_a.claim_addr;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        nchk++;
        if (got === want) npass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic pop(input int c, input int p, input data_t d, input logic b);
        exp_t e;
        nchk++;
        if (q.size() == 0) begin
            $display("FAIL pop_c%0d_p%0d: got output with empty queue, expected a queued entry", c, p);
            return;
        end
        e = q.pop_front();
        if (int'(e.c) == c && int'(e.port) == p && e.data === d && e.busy === b) npass++;
        else $display("FAIL out_c%0d_p%0d: got data=%h busy=%b, expected c%0d p%0d data=%h busy=%b",
                      c, p, d, b, e.c, e.port, e.data, e.busy);
    endtask

    always @(posedge clk) begin
        act_d <= act;
        en_d  <= bus_a.rd_en;
    end

    // monitor: one entry per enabled read port per build, then that build's claim_hit
    always @(negedge clk) begin
        if (act_d)
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < NR; i++)
                    if (en_d[i])
                        pop(c, i, c == 0 ? bus_a.rd_data[i*DW +: DW] : bus_b.rd_data[i*DW +: DW],
                            c == 0 ? bus_a.rd_busy[i] : bus_b.rd_busy[i]);
                pop(c, 2, '0, c == 0 ? bus_a.claim_hit : bus_b.claim_hit);
            end
    end

    // model: build 0 is bypass + hardwired r0, build 1 is read-first + ordinary r0
    task automatic step(input logic [NR-1:0] re, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        input logic [NW-1:0] we, input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                        input data_t d0, input data_t d1, input logic ce, input logic [AW-1:0] ca);
        logic [AW-1:0] rda [NR];
        logic [AW-1:0] wra [NW];
        data_t wdd [NW];
        logic nbusy [DEPTH];
        logic bp, zr, hitw;
        data_t d;
        logic b;
        exp_t e;
        rda = '{r0, r1};
        wra = '{w0, w1};
        wdd = '{d0, d1};
        bus_a.rd_en = re;
        bus_a.rd_addr = {r1, r0};
        bus_a.wr_en = we;
        bus_a.wr_addr = {w1, w0};
        bus_a.wr_data = {d1, d0};
        bus_a.claim_en = ce;
        bus_a.claim_addr = ca;
        act = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bp = (c == 0);
            zr = (c == 0);
            for (int a = 0; a < DEPTH; a++) begin
                hitw = 1'b0;
                for (int j = 0; j < NW; j++) if (we[j] && wra[j] == AW'(a)) hitw = 1'b1;
                nbusy[a] = (zr && a == 0) ? 1'b0 : (ce && ca == AW'(a)) ? 1'b1 : hitw ? 1'b0 : busy_m[c][a];
            end
            for (int i = 0; i < NR; i++)
                if (re[i]) begin
                    d = mem_m[c][rda[i]];
                    if (bp) for (int j = 0; j < NW; j++) if (we[j] && wra[j] == rda[i]) d = wdd[j];
                    b = bp ? nbusy[rda[i]] : busy_m[c][rda[i]];
                    if (zr && rda[i] == '0) begin d = '0; b = 1'b0; end
                    e.c = 2'(c); e.port = 2'(i); e.data = d; e.busy = b;
                    q.push_back(e);
                end
            e.c = 2'(c); e.port = 2'd2; e.data = '0;
            e.busy = ce && busy_m[c][ca] && !(zr && ca == '0);
            q.push_back(e);
            for (int a = 0; a < DEPTH; a++) busy_m[c][a] = nbusy[a];
            for (int j = 0; j < NW; j++)
                if (we[j] && !(zr && wra[j] == '0)) mem_m[c][wra[j]] = wdd[j];
        end
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[c][a] = '0;
                busy_m[c][a] = 1'b0;
            end
    endtask

    task automatic idle();
        bus_a.rd_en = '0; bus_a.rd_addr = '0; bus_a.wr_en = '0; bus_a.wr_addr = '0;
        bus_a.wr_data = '0; bus_a.claim_en = 1'b0; bus_a.claim_addr = '0;
    endtask

    task automatic rand_steps(input int n);
        for (int k = 0; k < n; k++)
            step(NR'($urandom), rnd_addr(), rnd_addr(), NW'($urandom), rnd_addr(), rnd_addr(),
                 $urandom, $urandom, $urandom_range(0, 2) == 0, rnd_addr());
    endtask

    initial begin
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rd_data_a", bus_a.rd_data[DW-1:0], '0);
        chk("reset_rd_data_b", bus_b.rd_data[2*DW-1:DW], '0);
        chk("reset_rd_busy_a", DW'(bus_a.rd_busy), '0);
        chk("reset_claim_hit_b", DW'(bus_b.claim_hit), '0);
        rst_n = 1'b1;
        @(negedge clk);
        // same-cycle write/read of r5, then a later read on both ports
        step(2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, '0, 1'b0, '0);
        chk("bypass_r5_a", bus_a.rd_data[DW-1:0], 32'hDEADBEEF);
        chk("readfirst_r5_b", bus_b.rd_data[DW-1:0], 32'h0);
        step(2'b11, 5'd5, 5'd5, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("next_r5_a", bus_a.rd_data[2*DW-1:DW], 32'hDEADBEEF);
        chk("next_r5_b", bus_b.rd_data[DW-1:0], 32'hDEADBEEF);
        // two writers on r7: port 1 wins
        step(2'b00, '0, '0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, '0);
        step(2'b01, 5'd7, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("conflict_r7_a", bus_a.rd_data[DW-1:0], 32'h22);
        chk("conflict_r7_b", bus_b.rd_data[DW-1:0], 32'h22);
        // register 0: hardwired in build a, ordinary in build b
        step(2'b00, '0, '0, 2'b01, 5'd0, '0, 32'hFFFFFFFF, '0, 1'b1, 5'd0);
        step(2'b11, 5'd0, 5'd0, 2'b00, '0, '0, '0, '0, 1'b1, 5'd0);
        chk("zero_data_a", bus_a.rd_data[DW-1:0], '0);
        chk("zero_busy_a", DW'(bus_a.rd_busy), '0);
        chk("zero_claim_hit_a", DW'(bus_a.claim_hit), '0);
        chk("r0_data_b", bus_b.rd_data[2*DW-1:DW], 32'hFFFFFFFF);
        chk("r0_claim_hit_b", DW'(bus_b.claim_hit), 32'h1);
        // busy scoreboard on r3
        step(2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1, 5'd3);
        step(2'b01, 5'd3, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("claimed_busy_a", DW'(bus_a.rd_busy[0]), 32'h1);
        chk("claimed_busy_b", DW'(bus_b.rd_busy[0]), 32'h1);
        step(2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1, 5'd3);
        chk("reclaim_hit_a", DW'(bus_a.claim_hit), 32'h1);
        chk("reclaim_hit_b", DW'(bus_b.claim_hit), 32'h1);
        step(2'b00, '0, '0, 2'b01, 5'd3, '0, 32'h5, '0, 1'b0, '0);
        step(2'b01, 5'd3, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("released_busy_a", DW'(bus_a.rd_busy[0]), 32'h0);
        chk("released_data_b", bus_b.rd_data[DW-1:0], 32'h5);
        step(2'b00, '0, '0, 2'b01, 5'd3, '0, 32'h7, '0, 1'b1, 5'd3);
        step(2'b01, 5'd3, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("claim_wins_a", DW'(bus_a.rd_busy[0]), 32'h1);
        chk("claim_wins_b", DW'(bus_b.rd_busy[0]), 32'h1);
        rand_steps(3000);
        // reset mid-stream with a write and claim in flight
        bus_a.rd_en = '0;
        bus_a.wr_en = 2'b11; bus_a.wr_addr = {5'd9, 5'd10}; bus_a.wr_data = {32'h1234, 32'h5678};
        bus_a.claim_en = 1'b1; bus_a.claim_addr = 5'd9;
        act = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            chk("midrst_data_a", bus_a.rd_data[i*DW +: DW], '0);
            chk("midrst_data_b", bus_b.rd_data[i*DW +: DW], '0);
        end
        chk("midrst_busy_b", DW'(bus_b.rd_busy), '0);
        chk("midrst_claim_hit_a", DW'(bus_a.claim_hit), '0);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        step(2'b11, 5'd9, 5'd10, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("post_rst_r9_a", bus_a.rd_data[DW-1:0], '0);
        chk("post_rst_r10_b", bus_b.rd_data[2*DW-1:DW], '0);
        chk("post_rst_busy_b", DW'(bus_b.rd_busy), '0);
        rand_steps(1500);
        act = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", DW'(q.size()), '0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
